// File: rtl/writeback_arb_pkg.sv
// writeback_arb_pkg: shared microarchitecture widths and round-robin pointer helper
package writeback_arb_pkg;
   localparam int c_pc_bits = 32;
   localparam int c_reg_addr_bits = 5;
   localparam int c_data_bits = 32;
   function automatic int rr_next(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction
endpackage

// File: rtl/writeback_arb_rr_arb.sv
// rr_arb: one-hot round-robin grant starting at ptr and searching upward modulo p_n
module rr_arb #(
   parameter int p_n  = 2,
   parameter int p_pb = 1
) (
   input  logic [p_n-1:0]  req,
   input  logic [p_pb-1:0] ptr,
   output logic [p_n-1:0]  grant
);
   logic [2*p_n-1:0] dbl, gdbl;
   logic [p_n-1:0]   rot, gr;
   // rotate so ptr sits at bit 0, isolate lowest request, rotate back
   assign dbl   = {req, req} >> ptr;
   assign rot   = dbl[p_n-1:0];
   assign gr    = rot & (-rot);
   assign gdbl  = {gr, gr} << ptr;
   assign grant = gdbl[2*p_n-1:p_n];
endmodule

// File: rtl/writeback_arb.sv
// writeback_arb: round-robin merge of execute pipes into one registered writeback port (optional WRITEBACK_ARB_STALL_CNT_EN adds stall_cnt)
module writeback_arb
   import writeback_arb_pkg::*;
#(
   parameter int p_num_pipes    = 2,
   parameter int p_seq_num_bits = 5
) (
   input  logic                                         clk,
   input  logic                                         rst,
`ifdef WRITEBACK_ARB_STALL_CNT_EN
   output logic [31:0]                                  stall_cnt,
`endif
   input  logic [p_num_pipes-1:0]                       ex_val,
   output logic [p_num_pipes-1:0]                       ex_rdy,
   input  logic [p_num_pipes-1:0][c_pc_bits-1:0]        ex_pc,
   input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]   ex_seq_num,
   input  logic [p_num_pipes-1:0][c_reg_addr_bits-1:0]  ex_waddr,
   input  logic [p_num_pipes-1:0][c_data_bits-1:0]      ex_wdata,
   input  logic [p_num_pipes-1:0]                       ex_wen,
   output logic                                         wb_val,
   input  logic                                         wb_rdy,
   output logic [c_pc_bits-1:0]                         wb_pc,
   output logic [p_seq_num_bits-1:0]                    wb_seq_num,
   output logic [c_reg_addr_bits-1:0]                   wb_waddr,
   output logic [c_data_bits-1:0]                       wb_wdata,
   output logic                                         wb_wen
);
   localparam int c_pb = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
   logic [c_pb-1:0]        ptr, sel;
   logic [p_num_pipes-1:0] grant;
   logic                   adv, xfer;
   rr_arb #(.p_n(p_num_pipes), .p_pb(c_pb)) u_rr (
      .req  (ex_val),
      .ptr  (ptr),
      .grant(grant)
   );
   assign adv    = !wb_val || wb_rdy;
   assign ex_rdy = (rst || !adv) ? '0 : grant;
   assign xfer   = |(ex_val & ex_rdy);
   always_comb begin
      sel = '0;
      for (int i = 0; i < p_num_pipes; i++)
         if (grant[i]) sel = c_pb'(i);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_val     <= 1'b0;
         ptr        <= '0;
         wb_pc      <= '0;
         wb_seq_num <= '0;
         wb_waddr   <= '0;
         wb_wdata   <= '0;
         wb_wen     <= 1'b0;
      end else if (xfer) begin
         wb_val     <= 1'b1;
         ptr        <= c_pb'(rr_next(int'(sel), p_num_pipes));
         wb_pc      <= ex_pc[sel];
         wb_seq_num <= ex_seq_num[sel];
         wb_waddr   <= ex_waddr[sel];
         wb_wdata   <= ex_wdata[sel];
         // x0 is hardwired zero, so a write to it is dropped here
         wb_wen     <= ex_wen[sel] && (ex_waddr[sel] != '0);
      end else if (wb_rdy) begin
         wb_val     <= 1'b0;
      end
   end
`ifdef WRITEBACK_ARB_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) stall_cnt <= '0;
      else if (|ex_val && !xfer && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
   end
`endif
endmodule

// File: doc/writeback_arb.md
WRITEBACK_ARB -- requirements
Module: writeback_arb

Interface
REQ-001 Parameter p_num_pipes, default 2: number of execute pipes competing for the single writeback port (range 1..8).
REQ-002 Parameter p_seq_num_bits, default 5: width of the instruction sequence number.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ex_val  in  p_num_pipes  per-pipe completed-instruction valid.
REQ-006 ex_rdy  out  p_num_pipes  per-pipe accept; transfer when ex_val[i] && ex_rdy[i].
REQ-007 ex_pc  in  p_num_pipes x 32  per-pipe instruction PC.
REQ-008 ex_seq_num  in  p_num_pipes x p_seq_num_bits  per-pipe sequence number.
REQ-009 ex_waddr  in  p_num_pipes x 5  per-pipe destination register.
REQ-010 ex_wdata  in  p_num_pipes x 32  per-pipe result.
REQ-011 ex_wen  in  p_num_pipes  per-pipe register-write enable.
REQ-012 wb_val  out  1  output message valid.
REQ-013 wb_rdy  in  1  downstream accept; transfer when wb_val && wb_rdy.
REQ-014 wb_pc, wb_seq_num, wb_waddr, wb_wdata, wb_wen  out  32/p_seq_num_bits/5/32/1  registered granted message.

Function
REQ-015 Arbitration SHALL be round-robin over pipes with ex_val high, starting at priority pointer ptr and searching upward modulo p_num_pipes.
REQ-016 At most one ex_rdy bit SHALL be high per cycle; ex_rdy[i] = grant[i] && (!wb_val || wb_rdy).
REQ-017 ex_rdy SHALL NOT depend combinationally on ex_val of the same pipe beyond the grant logic (no ready without valid).
REQ-018 On an ex-side transfer from pipe i, the output register SHALL load pipe i's message and ptr SHALL become (i+1) mod p_num_pipes next cycle.
REQ-019 With no ex-side transfer, ptr SHALL hold.
REQ-020 Latency SHALL be exactly one cycle from ex transfer to wb_val high.
REQ-021 While wb_val && !wb_rdy, all wb_* outputs SHALL hold stable and all ex_rdy SHALL be low.
REQ-022 Simultaneous wb transfer and ex transfer SHALL replace the message in the same cycle (full throughput, one instruction/cycle).
REQ-023 wb transfer with no ex transfer SHALL clear wb_val next cycle.
REQ-024 wb_wen SHALL be forced 0 when the captured waddr is 0 (x0 never written).
REQ-025 p_num_pipes == 1 SHALL degenerate to a pipeline register; ptr stays 0.

Reset
REQ-026 During rst: wb_val=0, ptr=0, ex_rdy all 0; wb data outputs 0.
REQ-027 Reset asserted mid-transfer SHALL discard the held message; first post-reset grant SHALL go to the lowest-index valid pipe.

Configuration
REQ-028 Macro WRITEBACK_ARB_STALL_CNT_EN: when defined, adds output stall_cnt (32 bits) counting cycles with any ex_val high and no ex transfer; saturates at all-ones; cleared by rst.
REQ-029 Without WRITEBACK_ARB_STALL_CNT_EN, stall_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Register-address width (5) and PC width (32) SHALL come from the shared UArch package; no local redefinition.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arb (inputs req, ptr; output one-hot grant).
REQ-032 Output register and ptr SHALL live in writeback_arb.

Verification
REQ-033 Single pipe 0 sends pc=0x200,waddr=3,wdata=0xAB, wb_rdy=1 -> next cycle wb_val=1, wb_waddr=3, wb_wdata=0xAB, wb_wen=1.
REQ-034 Pipes 0,1 both valid every cycle, wb_rdy=1 -> grants alternate 0,1,0,1; wb_val high every cycle.
REQ-035 wb_rdy=0 for 3 cycles with wb_val=1 -> wb_* stable, ex_rdy=0; on wb_rdy=1 next message loads same cycle.
REQ-036 Pipe 1 sends waddr=0,wen=1 -> wb_wen=0, wb_val=1.
REQ-037 rst asserted while wb_val=1, ptr=1 -> next cycle wb_val=0; after release with both valid, pipe 0 granted first.
REQ-038 With WRITEBACK_ARB_STALL_CNT_EN, wb_rdy=0 and pipe 0 valid for 5 cycles after wb_val=1 -> stall_cnt=5.
